// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard, forwarding and multiplier sequencing for the 5-stage RV32 pipeline.
// Ports: ID-stage instruction descriptor and EX branch outcome in; stall/bubble/flush/freeze
//   controls, rs1/rs2 forwarding selects, multiplier busy flag and stall-cycle counter out.
// Build option HAZ_FWD_EN: forward from EX/MEM/WB; when undefined every RAW hazard stalls.
module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_ra_idx,
  input  logic [4:0]       id_rb_idx,
  input  logic             id_uses_ra,
  input  logic             id_uses_rb,
  input  logic             id_reg_wr,
  input  logic [4:0]       id_rd_idx,
  input  logic             id_is_load,
  input  logic             id_is_mul,
  input  logic             ex_take_branch,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic             freeze_ex,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             mul_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       mul;
  } slot_t;

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic       MUL_FRZ   = (MUL_LAT > 1);
  localparam logic       MUL_SHORT = (MUL_LAT == 2);
  localparam logic [3:0] MUL_LOAD  = 4'(MUL_LAT > 2 ? MUL_LAT - 2 : 0);

  slot_t            ex_q, mem_q, wb_q;
  slot_t            ex_d, mem_d, wb_d;
  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // WB only ever needs its writer fields for matching.
  logic unused_wb_flags;
  assign unused_wb_flags = wb_q.ld ^ wb_q.mul;

  function automatic logic src_hit(input logic uses, input logic [4:0] idx,
                                   input logic v, input logic wr, input logic [4:0] rd);
    // idx != 0 together with rd == idx already excludes x0 writers.
    return uses && (idx != 5'd0) && v && wr && (rd == idx);
  endfunction

  logic a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;
  assign a_ex  = id_valid && src_hit(id_uses_ra, id_ra_idx, ex_q.v,  ex_q.wr,  ex_q.rd);
  assign a_mem = id_valid && src_hit(id_uses_ra, id_ra_idx, mem_q.v, mem_q.wr, mem_q.rd);
  assign a_wb  = id_valid && src_hit(id_uses_ra, id_ra_idx, wb_q.v,  wb_q.wr,  wb_q.rd);
  assign b_ex  = id_valid && src_hit(id_uses_rb, id_rb_idx, ex_q.v,  ex_q.wr,  ex_q.rd);
  assign b_mem = id_valid && src_hit(id_uses_rb, id_rb_idx, mem_q.v, mem_q.wr, mem_q.rd);
  assign b_wb  = id_valid && src_hit(id_uses_rb, id_rb_idx, wb_q.v,  wb_q.wr,  wb_q.rd);

  logic       mul_trig, freeze, mul_last, haz;
  logic [1:0] sel_a, sel_b;

  // The first freeze cycle is spent in IDLE, so BUSY lasts MUL_LAT-2 cycles and
  // the whole freeze is MUL_LAT-1 cycles. With MUL_LAT==2 BUSY is never entered.
  assign mul_trig = (state_q == IDLE) && ex_q.v && ex_q.mul && MUL_FRZ;
  assign freeze   = mul_trig || (state_q == BUSY);
  // On the last freeze cycle the held EX slot drops its mul flag, so the
  // finished multiply spends one ordinary cycle in EX without re-triggering.
  assign mul_last = (mul_trig && MUL_SHORT) || ((state_q == BUSY) && (cnt_q == 4'd1));

`ifdef HAZ_FWD_EN
  // Only a load in EX cannot be forwarded; its data appears one stage later.
  assign haz   = (a_ex || b_ex) && ex_q.ld;
  assign sel_a = (a_ex && !ex_q.ld) ? 2'd1 : a_mem ? 2'd2 : a_wb ? 2'd3 : 2'd0;
  assign sel_b = (b_ex && !ex_q.ld) ? 2'd1 : b_mem ? 2'd2 : b_wb ? 2'd3 : 2'd0;
`else
  assign haz   = a_ex || a_mem || a_wb || b_ex || b_mem || b_wb;
  assign sel_a = 2'd0;
  assign sel_b = 2'd0;
`endif

  // Priority: freeze > taken-branch flush > hazard stall. All outputs are
  // forced low while rst is asserted, including the input-driven flush.
  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    fwd_a_sel   = 2'd0;
    fwd_b_sel   = 2'd0;
    if (!rst) begin
      fwd_a_sel = sel_a;
      fwd_b_sel = sel_b;
      if (freeze) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
      end else if (ex_take_branch) begin
        flush_if_id = 1'b1;
      end else if (haz) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

  assign freeze_ex    = freeze && !rst;
  assign mul_busy     = (state_q == BUSY) && !rst;
  assign stall_cycles = stall_cnt_q;

  always_comb begin
    wb_d  = mem_q;
    mem_d = ex_q;
    ex_d  = '0;
    if (freeze) begin
      mem_d = '0;
      ex_d  = ex_q;
      if (mul_last) ex_d.mul = 1'b0;
    end else if (id_valid && !stall_id && !flush_if_id) begin
      ex_d.v   = 1'b1;
      ex_d.rd  = id_rd_idx;
      ex_d.wr  = id_reg_wr;
      ex_d.ld  = id_is_load;
      ex_d.mul = id_is_mul;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mul_trig && !MUL_SHORT) begin
          state_d = BUSY;
          cnt_d   = MUL_LOAD;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = IDLE;
      end
    endcase
  end

  assign stall_cnt_d = (stall_id || freeze_ex) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector tables, mid-BUSY reset sequence and
// randomized stimulus against an occupancy-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int MUL_LAT = 4;
  localparam int CNT_W   = 32;
`ifdef HAZ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_uses_ra, id_uses_rb, id_reg_wr, id_is_load, id_is_mul;
  logic [4:0]       id_ra_idx, id_rb_idx, id_rd_idx;
  logic             ex_take_branch;
  logic             stall_if, stall_id, bubble_ex, flush_if_id, freeze_ex, mul_busy;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_cycles;

  pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ra_idx(id_ra_idx), .id_rb_idx(id_rb_idx),
    .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb), .id_reg_wr(id_reg_wr),
    .id_rd_idx(id_rd_idx), .id_is_load(id_is_load), .id_is_mul(id_is_mul),
    .ex_take_branch(ex_take_branch),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_if_id(flush_if_id), .freeze_ex(freeze_ex),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mul_busy(mul_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct { bit v; int ra; bit ua; int rb; bit ub; int rd; bit wr; bit ld; bit mul; bit br; } in_t;
  typedef struct { bit sif; bit sid; bit bub; bit fl; bit frz; int fa; int fb; bit busy; int cnt; } out_t;
  typedef struct { in_t i; out_t o; } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- helpers ----------------
  function automatic in_t ins(bit v, int ra, bit ua, int rb, bit ub, int rd,
                              bit wr, bit ld, bit mul, bit br);
    in_t x;
    x.v = v; x.ra = ra; x.ua = ua; x.rb = rb; x.ub = ub; x.rd = rd;
    x.wr = wr; x.ld = ld; x.mul = mul; x.br = br;
    return x;
  endfunction

  function automatic in_t nop();
    return ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic in_t alu(int ra, bit ua, int rb, bit ub, int rd);
    return ins(1, ra, ua, rb, ub, rd, 1, 0, 0, 0);
  endfunction
  function automatic in_t alu_br(int ra, bit ua, int rb, bit ub, int rd);
    return ins(1, ra, ua, rb, ub, rd, 1, 0, 0, 1);
  endfunction
  function automatic in_t lw(int ra, bit ua, int rd);
    return ins(1, ra, ua, 0, 0, rd, 1, 1, 0, 0);
  endfunction
  function automatic in_t mul(int rd);
    return ins(1, 0, 0, 0, 0, rd, 1, 0, 1, 0);
  endfunction

  function automatic out_t eo(bit sif, bit sid, bit bub, bit fl, bit frz,
                              int fa, int fb, bit busy, int cnt);
    out_t e;
    e.sif = sif; e.sid = sid; e.bub = bub; e.fl = fl; e.frz = frz;
    e.fa = fa; e.fb = fb; e.busy = busy; e.cnt = cnt;
    return e;
  endfunction
  function automatic out_t o_none(int fa, int fb, int cnt);
    return eo(0, 0, 0, 0, 0, fa, fb, 0, cnt);
  endfunction
  function automatic out_t o_stall(int fa, int fb, int cnt);
    return eo(1, 1, 1, 0, 0, fa, fb, 0, cnt);
  endfunction
  function automatic out_t o_flush(int fa, int fb, int cnt);
    return eo(0, 0, 0, 1, 0, fa, fb, 0, cnt);
  endfunction
  function automatic out_t o_frz(bit busy, int cnt);
    return eo(1, 1, 0, 0, 1, 0, 0, busy, cnt);
  endfunction

  function automatic vec_t mk(in_t i, out_t o);
    vec_t v;
    v.i = i; v.o = o;
    return v;
  endfunction

  task automatic drive(input in_t x);
    id_valid       = x.v;
    id_ra_idx      = 5'(x.ra);
    id_uses_ra     = x.ua;
    id_rb_idx      = 5'(x.rb);
    id_uses_rb     = x.ub;
    id_rd_idx      = 5'(x.rd);
    id_reg_wr      = x.wr;
    id_is_load     = x.ld;
    id_is_mul      = x.mul;
    ex_take_branch = x.br;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input out_t e);
    chk($sformatf("%s stall_if", tag),     int'(stall_if),     int'(e.sif));
    chk($sformatf("%s stall_id", tag),     int'(stall_id),     int'(e.sid));
    chk($sformatf("%s bubble_ex", tag),    int'(bubble_ex),    int'(e.bub));
    chk($sformatf("%s flush_if_id", tag),  int'(flush_if_id),  int'(e.fl));
    chk($sformatf("%s freeze_ex", tag),    int'(freeze_ex),    int'(e.frz));
    chk($sformatf("%s fwd_a_sel", tag),    int'(fwd_a_sel),    e.fa);
    chk($sformatf("%s fwd_b_sel", tag),    int'(fwd_b_sel),    e.fb);
    chk($sformatf("%s mul_busy", tag),     int'(mul_busy),     int'(e.busy));
    chk($sformatf("%s stall_cycles", tag), int'(stall_cycles), e.cnt);
  endtask

  // ---------------- reference model ----------------
  // Occupancy list: index 0 = EX, 1 = MEM, 2 = WB. A multiply is tracked only
  // as "freeze cycles still owed" rather than by a state machine.
  typedef struct { bit v; int rd; bit wr; bit ld; } mslot_t;
  mslot_t m_pipe[3];
  int     m_left;
  int     m_cnt;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) m_pipe[k] = '{0, 0, 0, 0};
    m_left = 0;
    m_cnt  = 0;
  endtask

  function automatic out_t model_out(input in_t x);
    out_t e;
    int   idx[2];
    bit   use_s[2];
    int   sel[2];
    bit   haz;
    e = eo(0, 0, 0, 0, 0, 0, 0, 0, m_cnt);
    idx[0] = x.ra; idx[1] = x.rb; use_s[0] = x.ua; use_s[1] = x.ub;
    haz = 0;
    for (int s = 0; s < 2; s++) begin
      sel[s] = 0;
      if (x.v && use_s[s] && idx[s] != 0) begin
        // walk oldest to youngest so the youngest match is the one left in sel
        for (int k = 2; k >= 0; k--) begin
          if (m_pipe[k].v && m_pipe[k].wr && m_pipe[k].rd == idx[s]) begin
            if (!FWD || (k == 0 && m_pipe[k].ld)) haz = 1;
            if (!(k == 0 && m_pipe[k].ld)) sel[s] = k + 1;
          end
        end
      end
      if (!FWD) sel[s] = 0;
    end
    e.fa   = sel[0];
    e.fb   = sel[1];
    e.frz  = (m_left > 0);
    e.busy = e.frz && (m_left < MUL_LAT - 1);
    if (e.frz) begin
      e.sif = 1; e.sid = 1;
    end else if (x.br) begin
      e.fl = 1;
    end else if (haz) begin
      e.sif = 1; e.sid = 1; e.bub = 1;
    end
    return e;
  endfunction

  task automatic model_step(input in_t x, input out_t e);
    m_pipe[2] = m_pipe[1];
    if (e.frz) begin
      m_pipe[1] = '{0, 0, 0, 0};
      m_left--;
    end else begin
      m_pipe[1] = m_pipe[0];
      if (x.v && !e.sid && !e.fl) begin
        m_pipe[0] = '{1, x.rd, x.wr, x.ld};
        if (x.mul && MUL_LAT > 1) m_left = MUL_LAT - 1;
      end else begin
        m_pipe[0] = '{0, 0, 0, 0};
      end
    end
    if (e.sid || e.frz) m_cnt++;
  endtask

  // A taken branch can never coincide with a multiply freeze.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      assert (!(ex_take_branch && freeze_ex))
      else begin
        n_bad++;
        $display("FAIL branch_during_freeze: branch=%0d freeze=%0d", ex_take_branch, freeze_ex);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    drive(nop());
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  vec_t tbl[$];

  initial begin
    // ---------- directed cycle-by-cycle table (from reset) ----------
`ifdef HAZ_FWD_EN
    tbl.push_back(mk(alu(1, 1, 2, 1, 5),     o_none(0, 0, 0)));   // ADD x5
    tbl.push_back(mk(alu(5, 1, 5, 1, 6),     o_none(1, 1, 0)));   // SUB x6,x5,x5: from EX
    tbl.push_back(mk(alu(5, 1, 5, 1, 14),    o_none(2, 2, 0)));   // x5 now in MEM
    tbl.push_back(mk(alu(5, 1, 6, 1, 15),    o_none(3, 2, 0)));   // x5 WB, x6 MEM
    tbl.push_back(mk(lw(0, 0, 7),            o_none(0, 0, 0)));   // LW x7
    tbl.push_back(mk(alu(7, 1, 0, 1, 8),     o_stall(0, 0, 0)));  // load-use
    tbl.push_back(mk(alu(7, 1, 0, 1, 8),     o_none(2, 0, 1)));   // issue, x7 from MEM
    tbl.push_back(mk(lw(0, 0, 10),           o_none(0, 0, 1)));   // LW x10
    tbl.push_back(mk(alu_br(10, 1, 8, 1, 11), o_flush(0, 2, 1))); // flush beats load-use
    tbl.push_back(mk(alu(11, 1, 0, 1, 12),   o_none(0, 0, 1)));   // flushed x11 never in EX
    tbl.push_back(mk(mul(9),                 o_none(0, 0, 1)));   // MUL x9
    tbl.push_back(mk(nop(),                  o_frz(0, 1)));
    tbl.push_back(mk(nop(),                  o_frz(1, 2)));
    tbl.push_back(mk(nop(),                  o_frz(1, 3)));
    tbl.push_back(mk(alu(9, 1, 9, 1, 13),    o_none(1, 1, 4)));   // MUL done, still in EX
    tbl.push_back(mk(alu(9, 1, 13, 1, 16),   o_none(2, 1, 4)));   // MUL reached MEM
`else
    tbl.push_back(mk(alu(1, 1, 0, 0, 3),     o_none(0, 0, 0)));   // ADDI x3
    tbl.push_back(mk(alu(3, 1, 3, 1, 4),     o_stall(0, 0, 0)));  // x3 in EX
    tbl.push_back(mk(alu(3, 1, 3, 1, 4),     o_stall(0, 0, 1)));  // x3 in MEM
    tbl.push_back(mk(alu(3, 1, 3, 1, 4),     o_stall(0, 0, 2)));  // x3 in WB
    tbl.push_back(mk(alu(3, 1, 3, 1, 4),     o_none(0, 0, 3)));   // issue
    tbl.push_back(mk(lw(2, 1, 7),            o_none(0, 0, 3)));   // LW x7
    tbl.push_back(mk(alu(7, 1, 0, 1, 8),     o_stall(0, 0, 3)));
    tbl.push_back(mk(alu(7, 1, 0, 1, 8),     o_stall(0, 0, 4)));
    tbl.push_back(mk(alu(7, 1, 0, 1, 8),     o_stall(0, 0, 5)));
    tbl.push_back(mk(alu(7, 1, 0, 1, 8),     o_none(0, 0, 6)));
    tbl.push_back(mk(lw(0, 0, 10),           o_none(0, 0, 6)));   // LW x10
    tbl.push_back(mk(alu_br(10, 1, 10, 1, 11), o_flush(0, 0, 6))); // flush beats load-use
    tbl.push_back(mk(alu(11, 1, 0, 1, 12),   o_none(0, 0, 6)));   // flushed x11 never in EX
    tbl.push_back(mk(mul(9),                 o_none(0, 0, 6)));   // MUL x9
    tbl.push_back(mk(nop(),                  o_frz(0, 6)));
    tbl.push_back(mk(nop(),                  o_frz(1, 7)));
    tbl.push_back(mk(nop(),                  o_frz(1, 8)));
    tbl.push_back(mk(nop(),                  o_none(0, 0, 9)));   // MUL's plain EX cycle
    tbl.push_back(mk(alu(9, 1, 9, 1, 13),    o_stall(0, 0, 9)));  // x9 in MEM
    tbl.push_back(mk(alu(9, 1, 9, 1, 13),    o_stall(0, 0, 10))); // x9 in WB
    tbl.push_back(mk(alu(9, 1, 9, 1, 13),    o_none(0, 0, 11)));
`endif

    // ---------- outputs while reset is held ----------
    rst = 1'b1;
    drive(alu_br(3, 1, 3, 1, 4));
    #2;
    check_out("in_reset", eo(0, 0, 0, 0, 0, 0, 0, 0, 0));

    do_reset();
    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].i);
      @(negedge clk);
      check_out($sformatf("vec%0d", k), tbl[k].o);
      @(posedge clk);
      #1;
    end

    // ---------- reset in the middle of BUSY ----------
    do_reset();
    drive(mul(9));
    @(posedge clk); #1;
    drive(nop());
    @(posedge clk); #1;
    @(posedge clk); #1;                // BUSY, two freeze cycles already counted
    chk("midbusy pre mul_busy", int'(mul_busy), 1);
    chk("midbusy pre freeze_ex", int'(freeze_ex), 1);
    chk("midbusy pre stall_cycles", int'(stall_cycles), 2);
    #1;
    rst = 1'b1;
    drive(alu_br(9, 1, 9, 1, 13));
    #1;
    check_out("midbusy_rst", eo(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b0;
    drive(alu(9, 1, 9, 1, 13));
    @(negedge clk);
    check_out("after_rst", eo(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;

    // ---------- randomized run against the model ----------
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      in_t  x;
      out_t e;
      int   kind;
      x.v   = ($urandom_range(0, 7) != 0);
      x.ra  = $urandom_range(0, 3);
      x.rb  = $urandom_range(0, 3);
      x.ua  = 1'($urandom_range(0, 1));
      x.ub  = 1'($urandom_range(0, 1));
      x.rd  = $urandom_range(0, 3);
      x.wr  = ($urandom_range(0, 4) != 0);
      kind  = $urandom_range(0, 9);
      x.ld  = (kind < 2);
      x.mul = (kind == 2);
      x.br  = (m_left == 0) && ($urandom_range(0, 9) == 0);
      drive(x);
      e = model_out(x);
      @(negedge clk);
      check_out($sformatf("rnd%0d", n), e);
      model_step(x, e);
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
